// File: rtl/xs3_decimal_decoder.sv
// -----------------------------------------------------------------------------
// xs3_decimal_decoder
//
// Clocked excess-3 to 1-of-10 decimal decoder (7443 function). The 4-bit
// XS-3 code {D,C,B,A} is sampled on the rising clock edge when en is high and
// the decoded digit appears on the registered Y outputs one cycle later.
// Codes outside 0011..1100 drive every Y inactive and raise err.
//
// Parameters:
//   ACTIVE_LOW  1: selected Y is 0, others 1 (7443 style). 0: polarity inverted.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, priority over en
//   en       in   sample enable; when low all registers hold
//   D,C,B,A  in   XS-3 code, D is the MSB
//   Y0..Y9   out  registered decoded outputs
//   err      out  registered flag: last sampled code was invalid
//   bcd      out  [3:0] registered BCD digit, 4'b1111 when invalid or after
//                 reset (only with XS3_BCD_OUT_EN)
//   bcd_vld  out  [0:0] registered digit-valid flag (only with XS3_BCD_OUT_EN)
//
// Optional feature macro: XS3_BCD_OUT_EN adds the bcd / bcd_vld outputs.
// -----------------------------------------------------------------------------
module xs3_decimal_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       D,
  input  logic       C,
  input  logic       B,
  input  logic       A,
  output logic       Y0,
  output logic       Y1,
  output logic       Y2,
  output logic       Y3,
  output logic       Y4,
  output logic       Y5,
  output logic       Y6,
  output logic       Y7,
  output logic       Y8,
  output logic       Y9,
  output logic       err
`ifdef XS3_BCD_OUT_EN
  ,
  output logic [3:0] bcd,
  output logic [0:0] bcd_vld
`endif
);

  // Active-high one-hot of the decoded digit; all zero for invalid codes.
  function automatic logic [9:0] xs3_onehot(input logic [3:0] code);
    logic [9:0] oh;
    case (code)
      4'b0011: oh = 10'b00_0000_0001;
      4'b0100: oh = 10'b00_0000_0010;
      4'b0101: oh = 10'b00_0000_0100;
      4'b0110: oh = 10'b00_0000_1000;
      4'b0111: oh = 10'b00_0001_0000;
      4'b1000: oh = 10'b00_0010_0000;
      4'b1001: oh = 10'b00_0100_0000;
      4'b1010: oh = 10'b00_1000_0000;
      4'b1011: oh = 10'b01_0000_0000;
      4'b1100: oh = 10'b10_0000_0000;
      default: oh = 10'b00_0000_0000;
    endcase
    return oh;
  endfunction

  // Valid XS-3 digits occupy 0011..1100; everything else is an error code.
  function automatic logic xs3_valid(input logic [3:0] code);
    logic v;
    case (code)
      4'b0000, 4'b0001, 4'b0010,
      4'b1101, 4'b1110, 4'b1111: v = 1'b0;
      default:                   v = 1'b1;
    endcase
    return v;
  endfunction

  // Map the internal active-high vector onto the pin polarity.
  function automatic logic [9:0] apply_polarity(input logic [9:0] act);
    logic [9:0] pins;
    if (ACTIVE_LOW) begin
      pins = ~act;
    end else begin
      pins = act;
    end
    return pins;
  endfunction

  localparam logic [9:0] Y_IDLE = ACTIVE_LOW ? 10'b11_1111_1111 : 10'b00_0000_0000;

  logic [3:0] code_s;
  logic       code_valid_s;
  logic [9:0] y_dec_s;

  logic [9:0] y_d,   y_q;
  logic       err_d, err_q;

  assign code_s = {D, C, B, A};

  // Decode the sampled code into pin-level Y values and the validity flag.
  always_comb begin
    code_valid_s = xs3_valid(code_s);
    y_dec_s      = apply_polarity(xs3_onehot(code_s));
  end

  // Next-state for Y / err: reset first, then sample on enable, else hold.
  always_comb begin
    y_d   = y_q;
    err_d = err_q;
    if (rst) begin
      y_d   = Y_IDLE;
      err_d = 1'b0;
    end else if (en) begin
      y_d   = y_dec_s;
      err_d = ~code_valid_s;
    end else begin
      y_d   = y_q;
      err_d = err_q;
    end
  end

  // Y / err state registers.
  always_ff @(posedge clk) begin
    y_q   <= y_d;
    err_q <= err_d;
  end

  assign Y0  = y_q[0];
  assign Y1  = y_q[1];
  assign Y2  = y_q[2];
  assign Y3  = y_q[3];
  assign Y4  = y_q[4];
  assign Y5  = y_q[5];
  assign Y6  = y_q[6];
  assign Y7  = y_q[7];
  assign Y8  = y_q[8];
  assign Y9  = y_q[9];
  assign err = err_q;

`ifdef XS3_BCD_OUT_EN
  logic [3:0] bcd_d,     bcd_q;
  logic       bcd_vld_d, bcd_vld_q;
  logic [3:0] digit_s;

  // Binary digit is simply code minus three; invalid codes report 4'b1111.
  always_comb begin
    digit_s = code_s - 4'd3;
    if (code_valid_s) begin
      digit_s = code_s - 4'd3;
    end else begin
      digit_s = 4'b1111;
    end
  end

  // Next-state for the BCD outputs, same reset / enable rules as Y.
  always_comb begin
    bcd_d     = bcd_q;
    bcd_vld_d = bcd_vld_q;
    if (rst) begin
      bcd_d     = 4'b1111;
      bcd_vld_d = 1'b0;
    end else if (en) begin
      bcd_d     = digit_s;
      bcd_vld_d = code_valid_s;
    end else begin
      bcd_d     = bcd_q;
      bcd_vld_d = bcd_vld_q;
    end
  end

  // BCD state registers.
  always_ff @(posedge clk) begin
    bcd_q     <= bcd_d;
    bcd_vld_q <= bcd_vld_d;
  end

  assign bcd     = bcd_q;
  assign bcd_vld = bcd_vld_q;
`endif

  xs3_decimal_decoder_chk #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_chk (
    .clk (clk),
    .rst (rst),
    .y   (y_q),
    .err (err_q)
  );

endmodule

// -----------------------------------------------------------------------------
// xs3_decimal_decoder_chk
//
// Invariant checker for the decoder state: at most one Y active, and none
// active while err is set.
//
// Ports:
//   clk  in  clock
//   rst  in  reset; checks are skipped while it is asserted
//   y    in  [9:0] pin-level Y register
//   err  in  err register
// -----------------------------------------------------------------------------
module xs3_decimal_decoder_chk #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic       clk,
  input logic       rst,
  input logic [9:0] y,
  input logic       err
);

  logic [9:0] act_s;
  logic       armed_q;

  // Convert pin polarity back to an active-high vector for counting.
  always_comb begin
    if (ACTIVE_LOW) begin
      act_s = ~y;
    end else begin
      act_s = y;
    end
  end

  // Arm the checks once a reset has been seen, so power-up X is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_q;
    end
  end

  // Registered-state invariants.
  always_ff @(posedge clk) begin
    if (armed_q === 1'b1 && !rst) begin
      assert ($countones(act_s) <= 1);
      assert (!(err && (act_s != 10'b00_0000_0000)));
    end
  end

endmodule

// File: tb/tb_xs3_decimal_decoder.sv
module tb_xs3_decimal_decoder;

  logic clk = 1'b0;
  logic rst, en, D, C, B, A;
  logic [9:0] ylo, yhi;
  logic errlo, errhi;
`ifdef XS3_BCD_OUT_EN
  logic [3:0] bcd_lo, bcd_hi;
  logic [0:0] vld_lo, vld_hi;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: decimal digit held (-1 = none active), err, bcd valid
  int m_digit;
  bit m_err;
  bit m_vld;

  always #5 clk = ~clk;

  xs3_decimal_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .D(D), .C(C), .B(B), .A(A),
    .Y0(ylo[0]), .Y1(ylo[1]), .Y2(ylo[2]), .Y3(ylo[3]), .Y4(ylo[4]),
    .Y5(ylo[5]), .Y6(ylo[6]), .Y7(ylo[7]), .Y8(ylo[8]), .Y9(ylo[9]),
    .err(errlo)
`ifdef XS3_BCD_OUT_EN
    , .bcd(bcd_lo), .bcd_vld(vld_lo)
`endif
  );

  xs3_decimal_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .D(D), .C(C), .B(B), .A(A),
    .Y0(yhi[0]), .Y1(yhi[1]), .Y2(yhi[2]), .Y3(yhi[3]), .Y4(yhi[4]),
    .Y5(yhi[5]), .Y6(yhi[6]), .Y7(yhi[7]), .Y8(yhi[8]), .Y9(yhi[9]),
    .err(errhi)
`ifdef XS3_BCD_OUT_EN
    , .bcd(bcd_hi), .bcd_vld(vld_hi)
`endif
  );

  task automatic drive(input logic r, input logic e, input logic [3:0] code);
    rst = r;
    en  = e;
    {D, C, B, A} = code;
  endtask

  // One clock: model absorbs the values present at the edge, then settle.
  task automatic tick();
    int c;
    @(posedge clk);
    c = int'({D, C, B, A});
    if (rst) begin
      m_digit = -1; m_err = 1'b0; m_vld = 1'b0;
    end else if (en) begin
      if (c >= 3 && c <= 12) begin
        m_digit = c - 3; m_err = 1'b0; m_vld = 1'b1;
      end else begin
        m_digit = -1; m_err = 1'b1; m_vld = 1'b0;
      end
    end
    #1;
  endtask

  // Expected pin vector: selected digit active at the instance's polarity.
  function automatic logic [9:0] exp_y(input bit active_low);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) begin
      v[i] = active_low ? (i != m_digit) : (i == m_digit);
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_bcd();
    logic [3:0] b;
    b = (m_digit >= 0) ? 4'(m_digit) : 4'b1111;
    return b;
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b0, 4'b0011);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({ylo, yhi, errlo, errhi} !== {10'h3FF, 10'h000, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset cyc%0d got lo=%b hi=%b err=%b%b exp lo=3ff hi=000 err=00",
                 k, ylo, yhi, errlo, errhi);
      end
`ifdef XS3_BCD_OUT_EN
      checks++;
      if ({bcd_lo, vld_lo} !== {4'b1111, 1'b0}) begin
        failures++;
        $display("FAIL reset_bcd got bcd=%b vld=%b exp bcd=1111 vld=0", bcd_lo, vld_lo);
      end
`endif
    end
  endtask

  task automatic test_invalid_low();
    logic [3:0] seq [2];
    seq[0] = 4'b0000;
    seq[1] = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, seq[k]);
      tick();
      checks++;
      if ({ylo, yhi, errlo, errhi} !== {exp_y(1'b1), exp_y(1'b0), m_err, m_err}) begin
        failures++;
        $display("FAIL invalid_low code=%b got lo=%b hi=%b err=%b%b exp lo=%b hi=%b err=%b",
                 seq[k], ylo, yhi, errlo, errhi, exp_y(1'b1), exp_y(1'b0), m_err);
      end
    end
  endtask

  task automatic test_sweep();
    for (int c = 3; c <= 12; c++) begin
      drive(1'b0, 1'b1, 4'(c));
      tick();
      checks++;
      if ({ylo, yhi, errlo, errhi} !== {exp_y(1'b1), exp_y(1'b0), 1'b0, 1'b0}
          || $countones(~ylo) != 1) begin
        failures++;
        $display("FAIL sweep code=%0d got lo=%b hi=%b err=%b%b exp lo=%b hi=%b err=00",
                 c, ylo, yhi, errlo, errhi, exp_y(1'b1), exp_y(1'b0));
      end
`ifdef XS3_BCD_OUT_EN
      checks++;
      if ({bcd_lo, vld_lo, bcd_hi, vld_hi} !== {4'(c - 3), 1'b1, 4'(c - 3), 1'b1}) begin
        failures++;
        $display("FAIL sweep_bcd code=%0d got bcd=%0d vld=%b exp bcd=%0d vld=1",
                 c, bcd_lo, vld_lo, c - 3);
      end
`endif
    end
  endtask

  task automatic test_invalid_high();
    for (int c = 13; c <= 15; c++) begin
      drive(1'b0, 1'b1, 4'(c));
      tick();
      checks++;
      if ({ylo, yhi, errlo, errhi} !== {10'h3FF, 10'h000, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL invalid_high code=%0d got lo=%b hi=%b err=%b%b exp lo=3ff hi=000 err=11",
                 c, ylo, yhi, errlo, errhi);
      end
`ifdef XS3_BCD_OUT_EN
      checks++;
      if ({bcd_lo, vld_lo} !== {4'b1111, 1'b0}) begin
        failures++;
        $display("FAIL invalid_high_bcd got bcd=%b vld=%b exp bcd=1111 vld=0", bcd_lo, vld_lo);
      end
`endif
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 4'b0111);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 4'b1100);
      #2 {D, C, B, A} = 4'(k);   // wiggle between edges, must be ignored
      #2 {D, C, B, A} = 4'b1100;
      tick();
      checks++;
      if (ylo !== 10'b11_1110_1111 || yhi !== 10'b00_0001_0000 || errlo !== 1'b0) begin
        failures++;
        $display("FAIL hold cyc%0d got lo=%b hi=%b err=%b exp lo=1111101111 hi=0000010000 err=0",
                 k, ylo, yhi, errlo);
      end
    end
    drive(1'b0, 1'b1, 4'b1100);
    tick();
    checks++;
    if (ylo !== 10'b01_1111_1111 || yhi !== 10'b10_0000_0000) begin
      failures++;
      $display("FAIL hold_release got lo=%b hi=%b exp lo=0111111111 hi=1000000000", ylo, yhi);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 1'b1, 4'b0000);   // leave err set so reset has something to clear
    tick();
    drive(1'b1, 1'b1, 4'b1000);
    tick();
    checks++;
    if ({ylo, yhi, errlo, errhi} !== {10'h3FF, 10'h000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_priority got lo=%b hi=%b err=%b%b exp lo=3ff hi=000 err=00",
               ylo, yhi, errlo, errhi);
    end
    drive(1'b0, 1'b1, 4'b0101);
    tick();
    checks++;
    if (yhi !== 10'b00_0000_0100 || ylo !== 10'b11_1111_1011) begin
      failures++;
      $display("FAIL polarity_y2 got hi=%b lo=%b exp hi=0000000100 lo=1111111011", yhi, ylo);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(3) != 0), 4'($urandom_range(15)));
      tick();
      checks++;
      if ({ylo, yhi, errlo, errhi} !== {exp_y(1'b1), exp_y(1'b0), m_err, m_err}) begin
        failures++;
        $display("FAIL random it%0d got lo=%b hi=%b err=%b%b exp lo=%b hi=%b err=%b",
                 k, ylo, yhi, errlo, errhi, exp_y(1'b1), exp_y(1'b0), m_err);
      end
`ifdef XS3_BCD_OUT_EN
      checks++;
      if ({bcd_lo, vld_lo, bcd_hi, vld_hi} !== {exp_bcd(), m_vld, exp_bcd(), m_vld}) begin
        failures++;
        $display("FAIL random_bcd it%0d got bcd=%b vld=%b exp bcd=%b vld=%b",
                 k, bcd_lo, vld_lo, exp_bcd(), m_vld);
      end
`endif
    end
  endtask

  initial begin
    m_digit = -1; m_err = 1'b0; m_vld = 1'b0;
    drive(1'b1, 1'b0, 4'b0011);
    test_reset();
    test_invalid_low();
    test_sweep();
    test_invalid_high();
    test_hold();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
